// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- multiply/divide unit with HI/LO registers for a pipelined MIPS core.
//
// Operations are launched from the E stage. mult/multu/madd keep busy high for
// 5 cycles and div/divu for 10. HI/LO are written on the edge where busy drops.
// mthi/mtlo write one register in a single cycle without asserting busy.
//
// Ports:
//   clk        in   1   clock; all state changes on the rising edge
//   reset      in   1   asynchronous active-high reset
//   mdu_start  in   1   launch pulse for mult/multu/div/divu/madd
//   mdu_mod    in   3   000 mult, 001 multu, 010 div, 011 divu,
//                       100 mthi, 101 mtlo, 110 madd, 111 none
//   a, b       in  32   forwarded rs / rt operands
//   busy       out  1   a multi-cycle operation is in progress (registered)
//   hi, lo     out 32   HI / LO architectural registers (registered)
// -----------------------------------------------------------------------------
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdu_start,
  input  logic [2:0]  mdu_mod,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_NONE  = 3'b111;

  localparam logic [3:0] MUL_LAST = 4'd4;  // 5 busy cycles
  localparam logic [3:0] DIV_LAST = 4'd9;  // 10 busy cycles

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  cnt_q;

  // Pending result, computed from the latched operands. The operands are
  // stable for the whole RUN period, so the arithmetic has several cycles to
  // settle before it is captured into hi/lo.
  logic [31:0] res_hi_d;
  logic [31:0] res_lo_d;

  logic        launch;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] b_safe;
  logic [31:0] b_abs_safe;

  assign launch = mdu_start &&
                  (mdu_mod == OP_MULT || mdu_mod == OP_MULTU || mdu_mod == OP_DIV ||
                   mdu_mod == OP_DIVU || mdu_mod == OP_MADD);

  always_comb begin
    // Low 64 bits of a product of sign-extended operands equal the signed
    // 32x32 product, so one unsigned 64-bit multiplier serves both cases.
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};

    // A zero divisor is replaced by 1 purely to keep the divider defined;
    // the result is discarded in that case.
    b_safe     = (b_q == 32'd0) ? 32'd1 : b_q;
    a_abs      = a_q[31] ? (32'd0 - a_q) : a_q;
    b_abs      = b_q[31] ? (32'd0 - b_q) : b_q;
    b_abs_safe = (b_abs == 32'd0) ? 32'd1 : b_abs;

    // Signed division via magnitudes: quotient negative when signs differ,
    // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
    // 0x80000000 rem 0 because the magnitude 0x80000000 is representable.
    sq_mag = a_abs / b_abs_safe;
    sr_mag = a_abs % b_abs_safe;
    uq     = a_q / b_safe;
    ur     = a_q % b_safe;

    res_hi_d = hi;
    res_lo_d = lo;
    case (op_q)
      OP_MULT:  {res_hi_d, res_lo_d} = prod_s;
      OP_MULTU: {res_hi_d, res_lo_d} = prod_u;
      // hi/lo cannot change while busy, so the live {hi,lo} is the
      // accumulator value as of the start edge.
      OP_MADD:  {res_hi_d, res_lo_d} = {hi, lo} + prod_s;
      OP_DIV: begin
        if (b_q != 32'd0) begin
          res_lo_d = (a_q[31] ^ b_q[31]) ? (32'd0 - sq_mag) : sq_mag;
          res_hi_d = a_q[31] ? (32'd0 - sr_mag) : sr_mag;
        end
      end
      OP_DIVU: begin
        if (b_q != 32'd0) begin
          res_lo_d = uq;
          res_hi_d = ur;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NONE;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= 4'd0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mdu_mod == OP_MTHI) begin
            hi <= a;
          end else if (mdu_mod == OP_MTLO) begin
            lo <= a;
          end else if (launch) begin
            op_q    <= mdu_mod;
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= (mdu_mod == OP_DIV || mdu_mod == OP_DIVU) ? DIV_LAST : MUL_LAST;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // All inputs are ignored here; only the counter advances.
          if (cnt_q == 4'd0) begin
            hi      <= res_hi_d;
            lo      <= res_lo_d;
            busy    <= 1'b0;
            op_q    <= OP_NONE;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
